// File: rtl/rx_cfg_pkg.sv
// Shared constants and types for the receive configuration sequencer.
// Holds config field positions, XGMII control codes and the frame FSM state type.
package rx_cfg_pkg;

  localparam int CFG_W     = 53;
  localparam int FCS_BIT   = 34;
  localparam int RX_EN_BIT = 35;
  localparam int VLAN_BIT  = 36;

  localparam logic [7:0] START_CODE = 8'hFB;
  localparam logic [7:0] TERM_CODE  = 8'hFD;
  localparam logic [7:0] ERR_CODE   = 8'hFE;

  localparam int               MAX_FRAME_WORDS = 2400;
  localparam logic [CFG_W-1:0] RESET_CFG       = '0;

  typedef enum logic {IDLE, IN_FRAME} rx_state_e;

  // A control byte that closes a frame: terminate or error.
  function automatic logic is_eof_code(input logic [7:0] b);
    return (b == TERM_CODE) || (b == ERR_CODE);
  endfunction

endpackage

// File: rtl/rx_xgmii_delim_detect.sv
// Combinational frame delimiter decode on one 32-bit XGMII word.
// Start is only legal in lane 0; terminate/error may appear in any lane.
module rx_xgmii_delim_detect
  import rx_cfg_pkg::*;
(
  input  logic [31:0] rxd,
  input  logic [3:0]  rxc,
  output logic        sof,
  output logic        eof
);

  always_comb begin
    sof = rxc[0] && (rxd[7:0] == START_CODE);
    eof = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rxc[k] && is_eof_code(rxd[8*k +: 8])) eof = 1'b1;
    end
  end

endmodule

// File: rtl/rx_cfg_sequencer.sv
// Receive config sequencer: host writes go to a shadow word and are copied to
// cfg_active only between frames, so a frame always sees one stable config.
//
// state    | meaning
// IDLE     | between frames; a pending shadow may be committed
// IN_FRAME | frame in progress; cfg_active frozen, watchdog counting words
module rx_cfg_sequencer
  import rx_cfg_pkg::*;
#(
  parameter int               MAX_WORDS = MAX_FRAME_WORDS,
  parameter logic [CFG_W-1:0] RST_CFG   = RESET_CFG
)(
  input  logic             rxclk_2x,
  input  logic             reset_out,
  input  logic [31:0]      rxd,
  input  logic [3:0]       rxc,
  input  logic             cfg_wr_req,
  input  logic [CFG_W-1:0] cfg_wr_data,
  output logic             cfg_wr_ack,
  output logic [CFG_W-1:0] cfg_active,
  output logic             cfg_pending,
  output logic             rx_enable,
  output logic             frame_active,
  output logic             commit_pulse,
  output logic             frame_timeout
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  rx_state_e        state, state_nxt;
  logic [15:0]      word_cnt, word_cnt_nxt;
  logic             timeout_nxt;
  logic [CFG_W-1:0] shadow;
  logic             sof, eof;
  logic             wr_accept, commit;

  rx_xgmii_delim_detect u_delim (
    .rxd (rxd),
    .rxc (rxc),
    .sof (sof),
    .eof (eof)
  );

  always_ff @(posedge rxclk_2x or posedge reset_out) begin
    if (reset_out) begin
      state         <= IDLE;
      word_cnt      <= '0;
      frame_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      word_cnt      <= word_cnt_nxt;
      frame_timeout <= timeout_nxt;
    end
  end

  // eof wins over the watchdog when both land on the same word.
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (sof) begin
          state_nxt    = IN_FRAME;
          word_cnt_nxt = 16'd1;
        end
      end
      IN_FRAME: begin
        if (eof) begin
          state_nxt    = IDLE;
          word_cnt_nxt = '0;
        end else if (word_cnt == MAX_CNT) begin
          state_nxt    = IDLE;
          word_cnt_nxt = '0;
          timeout_nxt  = 1'b1;
        end else begin
          word_cnt_nxt = word_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_active = (state == IN_FRAME);

  // A write landing on the same edge pushes the commit out one cycle so the
  // newest shadow is what reaches cfg_active.
  assign wr_accept = cfg_wr_req && !cfg_wr_ack;
  assign commit    = (state == IDLE) && !sof && cfg_pending && !wr_accept;

  always_ff @(posedge rxclk_2x or posedge reset_out) begin
    if (reset_out) begin
      shadow       <= '0;
      cfg_pending  <= 1'b0;
      cfg_wr_ack   <= 1'b0;
      cfg_active   <= RST_CFG;
      rx_enable    <= RST_CFG[RX_EN_BIT];
      commit_pulse <= 1'b0;
    end else begin
      cfg_wr_ack   <= wr_accept;
      commit_pulse <= commit;
      if (wr_accept) begin
        shadow      <= cfg_wr_data;
        cfg_pending <= 1'b1;
      end else if (commit) begin
        cfg_pending <= 1'b0;
      end
      if (commit) begin
        cfg_active <= shadow;
        rx_enable  <= shadow[RX_EN_BIT];
      end
    end
  end

endmodule
